// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and helpers for the keypad scanner
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE} state_t;
  localparam logic [ROWS-1:0][COLS-1:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [1:0] first_low(input logic [3:0] c);
    first_low = c[0] ? (c[1] ? (c[2] ? 2'd3 : 2'd2) : 2'd1) : 2'd0;
  endfunction
endpackage

// File: rtl/module_sync_2ff.sv
// module_sync_2ff: two-flop synchronizer for asynchronous inputs
module module_sync_2ff #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // first stage may go metastable; second stage presents a settled value
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q <= RST_VAL;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/module_keypad_scan.sv
// module_keypad_scan: 4x4 keypad row scanner with debounce and valid/ready key output
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 27000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);
  localparam int SW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  state_t state, state_n;
  logic [1:0] row_idx, col_idx;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0] col_s;
  logic col_bit, scan_done, db_done, pressed, publish, row_adv, db_inc;
  module_sync_2ff #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(column),
    .q(col_s)
  );
  assign row = ~(4'b0001 << row_idx);
  // next state and the control strobes that drive the counters and output handshake
  always_comb begin
    col_bit = col_s[col_idx];
    scan_done = scan_cnt == SW'(SCAN_TICKS - 1);
    db_done = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    pressed = col_s != 4'hF;
    publish = state == DEBOUNCE && !col_bit && db_done;
    row_adv = (state == SCAN && scan_done && !pressed) || (state == WAIT_RELEASE && col_bit && db_done);
    db_inc = (state == DEBOUNCE && !col_bit && !db_done) || (state == WAIT_RELEASE && col_bit && !db_done);
    state_n = state == SCAN ? (scan_done && pressed ? DEBOUNCE : SCAN) :
              state == DEBOUNCE ? (col_bit ? SCAN : db_done ? WAIT_RELEASE : DEBOUNCE) :
              (col_bit && db_done ? SCAN : WAIT_RELEASE);
  end
  // state, counters and the single-entry key output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      scan_cnt <= '0;
      db_cnt <= '0;
      key_code <= 4'h0;
      key_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      row_idx <= row_adv ? row_idx + 2'd1 : row_idx;
      scan_cnt <= (state == SCAN && !scan_done) ? scan_cnt + 1'b1 : '0;
      db_cnt <= db_inc ? db_cnt + 1'b1 : '0;
      if (state == SCAN && scan_done && pressed) col_idx <= first_low(col_s);
      if (publish && (!key_valid || key_ready)) begin
        key_code <= KEY_MAP[row_idx][col_idx];
        key_valid <= 1'b1;
      end else begin
        if (publish) overrun <= 1'b1;
        if (key_ready) key_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_module_keypad_scan.sv
// tb_module_keypad_scan: directed keypad scenarios with a key-code scoreboard
module tb_module_keypad_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] column, row, key_code;
  logic key_valid, key_ready, overrun;
  logic [15:0] pressed = '0;
  logic [3:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int a0;
  module_keypad_scan #(.SCAN_TICKS(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .column(column),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  // keypad model: a held key pulls its column low while its row is driven low
  always_comb begin
    column = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) column[c] = 1'b0;
  end
  // every handshake must match the oldest expected key
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      accepts++;
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_empty: got key_code %h, expected no key", key_code);
      end
      if (sb.size() != 0) begin
        logic [3:0] e;
        e = sb.pop_front();
        vectors++;
        assert (key_code === e) else begin
          miscompares++;
          $error("FAIL sb_code: got %h, expected %h", key_code, e);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row === r && n < 64) begin tick(1); n++; end
    while (row !== r && n < 64) begin tick(1); n++; end
    chk("wait_row", {28'd0, row}, {28'd0, r});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    key_ready = 1'b1;
    tick(2);
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("scan_row", row, ~(32'd1 << (i % 4)) & 32'hF);
      chk("scan_valid", key_valid, 0);
      tick(4);
    end
    a0 = accepts;
    sb.push_back(4'h5);
    pressed[5] = 1'b1;
    tick(60);
    pressed = '0;
    tick(30);
    chk("t2_pulses", accepts - a0, 1);
    a0 = accepts;
    wait_row(4'b1011);
    pressed[10] = 1'b1;
    tick(3);
    pressed = '0;
    tick(4);
    chk("t3_row_held", row, 4'b1011);
    tick(20);
    chk("t3_valid", key_valid, 0);
    chk("t3_pulses", accepts - a0, 0);
    key_ready = 1'b0;
    sb.push_back(4'h1);
    pressed[0] = 1'b1;
    tick(40);
    pressed = '0;
    tick(30);
    pressed[14] = 1'b1;
    tick(40);
    pressed = '0;
    tick(30);
    chk("t4_valid", key_valid, 1);
    chk("t4_code", key_code, 4'h1);
    chk("t4_overrun", overrun, 1);
    key_ready = 1'b1;
    tick(1);
    chk("t4_accept", key_valid, 0);
    a0 = accepts;
    sb.push_back(4'h7);
    pressed[8] = 1'b1;
    pressed[9] = 1'b1;
    tick(40);
    pressed = '0;
    tick(30);
    chk("t5_pulses", accepts - a0, 1);
    chk("t5_sticky", overrun, 1);
    a0 = accepts;
    wait_row(4'b0111);
    pressed[13] = 1'b1;
    tick(5);
    chk("t6_no_pub", key_valid, 0);
    rst = 1'b1;
    pressed = '0;
    tick(1);
    chk("t6_row", row, 4'b1110);
    chk("t6_valid", key_valid, 0);
    chk("t6_overrun", overrun, 0);
    rst = 1'b0;
    tick(40);
    chk("t6_after_valid", key_valid, 0);
    chk("t6_pulses", accepts - a0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
